// File: rtl/rename_unit.sv
// N-wide register rename stage: map table, circular free list, intra-group bypass,
// commit-side freeing and multi-slot branch checkpoints with single-cycle restore.
module rename_unit #(
  parameter int Width   = 2,
  parameter int NumArch = 32,
  parameter int NumPhys = 64,
  parameter int NumCkpt = 4,
  localparam int AW   = $clog2(NumArch),
  localparam int PW   = $clog2(NumPhys),
  localparam int FL   = NumPhys - NumArch,
  localparam int FLW  = $clog2(FL),
  localparam int PTRW = FLW + 1,
  localparam int CW   = $clog2(NumCkpt)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [Width*AW-1:0]   in_rs1_i,
  input  logic [Width*AW-1:0]   in_rs2_i,
  input  logic [Width*AW-1:0]   in_rd_i,
  input  logic [Width-1:0]      in_rd_we_i,
  input  logic                  in_save_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [Width*PW-1:0]   out_rs1_o,
  output logic [Width*PW-1:0]   out_rs2_o,
  output logic [Width*PW-1:0]   out_rd_o,
  output logic [Width*PW-1:0]   out_old_rd_o,
  output logic [CW-1:0]         out_ckpt_id_o,
  input  logic [Width-1:0]      commit_valid_i,
  input  logic [Width*PW-1:0]   commit_old_rd_i,
  input  logic                  restore_i,
  input  logic [CW-1:0]         restore_id_i,
  input  logic [NumCkpt-1:0]    ckpt_free_i
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]          state_r;
  logic [FLW-1:0]      init_cnt_r;
  logic [PW-1:0]       map_r [NumArch];
  logic [PW-1:0]       fl_r [FL];
  logic [PTRW-1:0]     head_r;
  logic [PTRW-1:0]     tail_r;
  logic [NumCkpt-1:0]  ckpt_busy_r;
  logic [PW-1:0]       ckpt_map_r [NumCkpt][NumArch];
  logic [PTRW-1:0]     ckpt_head_r [NumCkpt];

  logic                out_valid_r;
  logic [Width*PW-1:0] out_rs1_r;
  logic [Width*PW-1:0] out_rs2_r;
  logic [Width*PW-1:0] out_rd_r;
  logic [Width*PW-1:0] out_old_rd_r;
  logic [CW-1:0]       out_ckpt_id_r;

  logic [Width-1:0]    alloc_s;
  logic [PW-1:0]       new_phys_s [Width];
  logic [PTRW-1:0]     n_alloc_s;
  logic [PTRW-1:0]     head_next_s;
  logic [FLW-1:0]      commit_idx_s [Width];
  logic [PTRW-1:0]     n_commit_s;
  logic [PTRW-1:0]     count_s;
  logic [Width*PW-1:0] rs1_ren_s;
  logic [Width*PW-1:0] rs2_ren_s;
  logic [Width*PW-1:0] rd_ren_s;
  logic [Width*PW-1:0] old_ren_s;
  logic [PW-1:0]       map_next_s [NumArch];
  logic                slot_avail_s;
  logic [CW-1:0]       slot_s;
  logic [NumCkpt-1:0]  slot_oh_s;
  logic [NumCkpt-1:0]  restore_oh_s;
  logic                run_s;
  logic                in_ready_s;
  logic                accept_s;

  // Allocating lanes take consecutive free-list entries starting at head.
  always_comb begin
    logic [PTRW-1:0] off_v;
    logic [PTRW-1:0] ptr_v;
    off_v = {PTRW{1'b0}};
    for (int k = 0; k < Width; k++) begin
      alloc_s[k]    = in_rd_we_i[k] && (in_rd_i[k*AW +: AW] != {AW{1'b0}});
      ptr_v         = head_r + off_v;
      new_phys_s[k] = fl_r[ptr_v[FLW-1:0]];
      off_v         = off_v + {{FLW{1'b0}}, alloc_s[k]};
    end
    n_alloc_s   = off_v;
    head_next_s = head_r + off_v;
  end

  // Committed registers land at consecutive slots starting at tail.
  always_comb begin
    logic [PTRW-1:0] off_v;
    logic [PTRW-1:0] ptr_v;
    off_v = {PTRW{1'b0}};
    for (int k = 0; k < Width; k++) begin
      ptr_v           = tail_r + off_v;
      commit_idx_s[k] = ptr_v[FLW-1:0];
      off_v           = off_v + {{FLW{1'b0}}, commit_valid_i[k]};
    end
    n_commit_s = off_v;
  end

  // Source and old-destination lookup with bypass from lower lanes of the same group.
  always_comb begin
    logic [AW-1:0] a1_v, a2_v, ad_v;
    logic [PW-1:0] p1_v, p2_v, pd_v;
    rs1_ren_s = {(Width*PW){1'b0}};
    rs2_ren_s = {(Width*PW){1'b0}};
    rd_ren_s  = {(Width*PW){1'b0}};
    old_ren_s = {(Width*PW){1'b0}};
    for (int j = 0; j < Width; j++) begin
      a1_v = in_rs1_i[j*AW +: AW];
      a2_v = in_rs2_i[j*AW +: AW];
      ad_v = in_rd_i[j*AW +: AW];
      p1_v = map_r[a1_v];
      p2_v = map_r[a2_v];
      pd_v = map_r[ad_v];
      for (int k = 0; k < j; k++) begin
        p1_v = (alloc_s[k] && (in_rd_i[k*AW +: AW] == a1_v)) ? new_phys_s[k] : p1_v;
        p2_v = (alloc_s[k] && (in_rd_i[k*AW +: AW] == a2_v)) ? new_phys_s[k] : p2_v;
        pd_v = (alloc_s[k] && (in_rd_i[k*AW +: AW] == ad_v)) ? new_phys_s[k] : pd_v;
      end
      rs1_ren_s[j*PW +: PW] = (a1_v == {AW{1'b0}}) ? {PW{1'b0}} : p1_v;
      rs2_ren_s[j*PW +: PW] = (a2_v == {AW{1'b0}}) ? {PW{1'b0}} : p2_v;
      rd_ren_s[j*PW +: PW]  = alloc_s[j] ? new_phys_s[j] : {PW{1'b0}};
      old_ren_s[j*PW +: PW] = alloc_s[j] ? pd_v : {PW{1'b0}};
    end
  end

  // Post-group map table; later lanes overwrite earlier ones on a shared rd.
  always_comb begin
    for (int i = 0; i < NumArch; i++) begin
      map_next_s[i] = map_r[i];
    end
    for (int k = 0; k < Width; k++) begin
      for (int i = 0; i < NumArch; i++) begin
        map_next_s[i] = (alloc_s[k] && (in_rd_i[k*AW +: AW] == AW'(i))) ? new_phys_s[k]
                                                                         : map_next_s[i];
      end
    end
  end

  // Lowest free checkpoint slot.
  always_comb begin
    slot_avail_s = 1'b0;
    slot_s       = {CW{1'b0}};
    for (int i = NumCkpt - 1; i >= 0; i--) begin
      slot_s       = ckpt_busy_r[i] ? slot_s : CW'(i);
      slot_avail_s = slot_avail_s | ~ckpt_busy_r[i];
    end
    slot_oh_s    = {{(NumCkpt-1){1'b0}}, 1'b1} << slot_s;
    restore_oh_s = {{(NumCkpt-1){1'b0}}, 1'b1} << restore_id_i;
  end

  assign count_s    = tail_r - head_r;
  assign run_s      = (state_r == StRun);
  assign in_ready_s = run_s && !restore_i && (!out_valid_r || out_ready_i) &&
                      (count_s >= n_alloc_s) && (!in_save_i || slot_avail_s);
  assign accept_s   = in_valid_i && in_ready_s;

  // Sequencer, pointers, map table and checkpoint occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= StInit;
      init_cnt_r  <= {FLW{1'b0}};
      head_r      <= {PTRW{1'b0}};
      tail_r      <= {PTRW{1'b0}};
      ckpt_busy_r <= {NumCkpt{1'b0}};
      for (int i = 0; i < NumArch; i++) begin
        map_r[i] <= PW'(i);
      end
    end else if (state_r == StInit) begin
      init_cnt_r <= init_cnt_r + FLW'(1'b1);
      if (init_cnt_r == FLW'(FL - 1)) begin
        state_r <= StRun;
        tail_r  <= PTRW'(FL);
      end
    end else begin
      tail_r <= tail_r + n_commit_s;
      if (restore_i) begin
        head_r      <= ckpt_head_r[restore_id_i];
        ckpt_busy_r <= ckpt_busy_r & ~ckpt_free_i & ~restore_oh_s;
        for (int i = 0; i < NumArch; i++) begin
          map_r[i] <= ckpt_map_r[restore_id_i][i];
        end
      end else if (accept_s) begin
        head_r      <= head_next_s;
        ckpt_busy_r <= (ckpt_busy_r & ~ckpt_free_i) | (in_save_i ? slot_oh_s : {NumCkpt{1'b0}});
        for (int i = 0; i < NumArch; i++) begin
          map_r[i] <= map_next_s[i];
        end
      end else begin
        ckpt_busy_r <= ckpt_busy_r & ~ckpt_free_i;
      end
    end
  end

  // Free-list storage: seeded during init, refilled by commit afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_r == StInit)) begin
      fl_r[init_cnt_r] <= PW'(NumArch) + PW'(init_cnt_r);
    end else if (rst_ni) begin
      for (int k = 0; k < Width; k++) begin
        if (commit_valid_i[k]) begin
          fl_r[commit_idx_s[k]] <= commit_old_rd_i[k*PW +: PW];
        end
      end
    end
  end

  // Checkpoint capture of the post-group map and head.
  always_ff @(posedge clk_i) begin
    if (rst_ni && accept_s && in_save_i) begin
      ckpt_head_r[slot_s] <= head_next_s;
      for (int i = 0; i < NumArch; i++) begin
        ckpt_map_r[slot_s][i] <= map_next_s[i];
      end
    end
  end

  // Output register: loads on accept, holds under backpressure, flushed by restore.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_r   <= 1'b0;
      out_rs1_r     <= {(Width*PW){1'b0}};
      out_rs2_r     <= {(Width*PW){1'b0}};
      out_rd_r      <= {(Width*PW){1'b0}};
      out_old_rd_r  <= {(Width*PW){1'b0}};
      out_ckpt_id_r <= {CW{1'b0}};
    end else if (run_s && restore_i) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      out_rs1_r     <= rs1_ren_s;
      out_rs2_r     <= rs2_ren_s;
      out_rd_r      <= rd_ren_s;
      out_old_rd_r  <= old_ren_s;
      out_ckpt_id_r <= in_save_i ? slot_s : {CW{1'b0}};
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready_o    = in_ready_s;
  assign out_valid_o   = out_valid_r;
  assign out_rs1_o     = out_rs1_r;
  assign out_rs2_o     = out_rs2_r;
  assign out_rd_o      = out_rd_r;
  assign out_old_rd_o  = out_old_rd_r;
  assign out_ckpt_id_o = out_ckpt_id_r;

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: init, allocation, bypass, x0, backpressure,
// checkpoint save/restore, slot exhaustion and free-list exhaustion with commit.
module tb_rename_unit;
  localparam int W  = 2;
  localparam int AW = 5;
  localparam int PW = 6;
  localparam int NC = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [W*AW-1:0] in_rs1_i, in_rs2_i, in_rd_i;
  logic [W-1:0]    in_rd_we_i;
  logic            in_save_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [W*PW-1:0] out_rs1_o, out_rs2_o, out_rd_o, out_old_rd_o;
  logic [CW-1:0]   out_ckpt_id_o;
  logic [W-1:0]    commit_valid_i;
  logic [W*PW-1:0] commit_old_rd_i;
  logic            restore_i;
  logic [CW-1:0]   restore_id_i;
  logic [NC-1:0]   ckpt_free_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_unit #(.Width(W), .NumArch(32), .NumPhys(64), .NumCkpt(NC)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
    .in_rd_we_i(in_rd_we_i), .in_save_i(in_save_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_rd_o(out_rd_o),
    .out_old_rd_o(out_old_rd_o), .out_ckpt_id_o(out_ckpt_id_o),
    .commit_valid_i(commit_valid_i), .commit_old_rd_i(commit_old_rd_i),
    .restore_i(restore_i), .restore_id_i(restore_id_i), .ckpt_free_i(ckpt_free_i)
  );

  function automatic logic [PW-1:0] lane(input logic [W*PW-1:0] v, input int k);
    return v[k*PW +: PW];
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_grp(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] ad, input logic aw,
                         input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                         input logic [AW-1:0] bd, input logic bw, input logic sv);
    in_rs1_i   = {b1, a1};
    in_rs2_i   = {b2, a2};
    in_rd_i    = {bd, ad};
    in_rd_we_i = {bw, aw};
    in_save_i  = sv;
    in_valid_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    in_valid_i = 1'b0;
    tick();
    tick();
    chk1("rst_out_valid", out_valid_o, 1'b0);
    chk1("rst_in_ready", in_ready_o, 1'b0);
    chkp("rst_out_rd0", lane(out_rd_o, 0), 6'd0);
    chkp("rst_out_old1", lane(out_old_rd_o, 1), 6'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk1("init_ready_low", in_ready_o, 1'b0);
      tick();
    end
    chk1("run_ready_high", in_ready_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    in_rs1_i = '0; in_rs2_i = '0; in_rd_i = '0; in_rd_we_i = '0; in_save_i = 1'b0;
    commit_valid_i = '0; commit_old_rd_i = '0;
    restore_i = 1'b0; restore_id_i = '0; ckpt_free_i = '0;

    do_reset();

    // First group after init: fresh phys 32/33, identity old mappings.
    set_grp(5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    #1 chk1("g1_ready", in_ready_o, 1'b1);
    tick();
    chk1("g1_valid", out_valid_o, 1'b1);
    chkp("g1_rd0", lane(out_rd_o, 0), 6'd32);
    chkp("g1_rd1", lane(out_rd_o, 1), 6'd33);
    chkp("g1_old0", lane(out_old_rd_o, 0), 6'd5);
    chkp("g1_old1", lane(out_old_rd_o, 1), 6'd6);

    // Back-to-back RAW plus intra-group bypass on rd=3.
    set_grp(5'd5, 5'd6, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0);
    tick();
    chkp("g2_rs1_0", lane(out_rs1_o, 0), 6'd32);
    chkp("g2_rs2_0", lane(out_rs2_o, 0), 6'd33);
    chkp("g2_rd0", lane(out_rd_o, 0), 6'd34);
    chkp("g2_old0", lane(out_old_rd_o, 0), 6'd3);
    chkp("g2_rs1_1", lane(out_rs1_o, 1), 6'd34);
    chkp("g2_rs2_1", lane(out_rs2_o, 1), 6'd34);
    chkp("g2_old1", lane(out_old_rd_o, 1), 6'd34);
    chkp("g2_rd1", lane(out_rd_o, 1), 6'd35);

    // x0 destination, non-writing lane; map for 3 holds lane1's phys.
    set_grp(5'd3, 5'd0, 5'd0, 1'b1, 5'd0, 5'd5, 5'd7, 1'b0, 1'b0);
    tick();
    chkp("g3_rs1_0", lane(out_rs1_o, 0), 6'd35);
    chkp("g3_rs2_0", lane(out_rs2_o, 0), 6'd0);
    chkp("g3_rd0", lane(out_rd_o, 0), 6'd0);
    chkp("g3_old0", lane(out_old_rd_o, 0), 6'd0);
    chkp("g3_rs1_1", lane(out_rs1_o, 1), 6'd0);
    chkp("g3_rs2_1", lane(out_rs2_o, 1), 6'd32);
    chkp("g3_rd1", lane(out_rd_o, 1), 6'd0);

    // Backpressure: outputs hold and nothing is accepted.
    out_ready_i = 1'b0;
    set_grp(5'd0, 5'd0, 5'd8, 1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_ready_low", in_ready_o, 1'b0);
      chk1("bp_valid_hold", out_valid_o, 1'b1);
      chkp("bp_rs1_hold", lane(out_rs1_o, 0), 6'd35);
      tick();
    end
    out_ready_i = 1'b1;
    #1 chk1("bp_release_ready", in_ready_o, 1'b1);
    tick();
    chkp("g4_rd0", lane(out_rd_o, 0), 6'd36);
    chkp("g4_rd1", lane(out_rd_o, 1), 6'd37);
    chkp("g4_old0", lane(out_old_rd_o, 0), 6'd8);
    chkp("g4_rs1_1", lane(out_rs1_o, 1), 6'd36);
    chkp("g4_old1", lane(out_old_rd_o, 1), 6'd9);

    // Mid-operation reset fully reinitialises.
    do_reset();

    set_grp(5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
    #1 chk1("gA_ready", in_ready_o, 1'b1);
    tick();
    chkp("gA_rd0", lane(out_rd_o, 0), 6'd32);
    chkp("gA_rd1", lane(out_rd_o, 1), 6'd33);
    chkp("gA_old0", lane(out_old_rd_o, 0), 6'd5);
    chkc("gA_ckpt_id", out_ckpt_id_o, 2'd0);
    set_grp(5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    tick();
    chkp("gB_rd0", lane(out_rd_o, 0), 6'd34);
    chkp("gB_old0", lane(out_old_rd_o, 0), 6'd32);
    set_grp(5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    tick();
    set_grp(5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chkp("gD_rd0", lane(out_rd_o, 0), 6'd38);
    chkp("gD_old0", lane(out_old_rd_o, 0), 6'd34);

    // Restore to A: nothing accepted in the restore cycle.
    set_grp(5'd5, 5'd6, 5'd9, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
    restore_i = 1'b1; restore_id_i = 2'd0;
    #1 chk1("rst_cycle_ready", in_ready_o, 1'b0);
    tick();
    restore_i = 1'b0;
    chk1("restore_valid_clr", out_valid_o, 1'b0);
    #1 chk1("post_restore_ready", in_ready_o, 1'b1);
    tick();
    chkp("gE_rd0", lane(out_rd_o, 0), 6'd34);
    chkp("gE_rs1_0", lane(out_rs1_o, 0), 6'd32);
    chkp("gE_rs2_0", lane(out_rs2_o, 0), 6'd33);
    chkp("gE_old0", lane(out_old_rd_o, 0), 6'd9);
    chkp("gE_rs1_1", lane(out_rs1_o, 1), 6'd7);

    // Occupy every checkpoint slot, then stall on the fifth save.
    set_grp(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < NC; i++) begin
      #1 chk1("fill_ready", in_ready_o, 1'b1);
      tick();
      chkc("fill_id", out_ckpt_id_o, CW'(i));
    end
    #1 chk1("slots_full_ready", in_ready_o, 1'b0);
    tick();
    #1 chk1("slots_full_ready2", in_ready_o, 1'b0);
    ckpt_free_i = 4'b0010;
    #1 chk1("free_cycle_ready", in_ready_o, 1'b0);
    tick();
    ckpt_free_i = 4'b0000;
    #1 chk1("after_free_ready", in_ready_o, 1'b1);
    tick();
    chkc("reuse_slot1", out_ckpt_id_o, 2'd1);

    // Drain the free list to one entry (head 3 -> 31).
    set_grp(5'd0, 5'd0, 5'd1, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick();
    end
    chkp("drain_rd0", lane(out_rd_o, 0), 6'd61);
    chkp("drain_rd1", lane(out_rd_o, 1), 6'd62);
    #1 chk1("fl_low_ready", in_ready_o, 1'b0);
    commit_valid_i  = 2'b01;
    commit_old_rd_i = {6'd0, 6'd5};
    tick();
    commit_valid_i  = 2'b00;
    commit_old_rd_i = '0;
    #1 chk1("after_commit_ready", in_ready_o, 1'b1);
    tick();
    chkp("wrap_rd0", lane(out_rd_o, 0), 6'd63);
    chkp("wrap_rd1", lane(out_rd_o, 1), 6'd5);

    in_valid_i = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_unit.md
# rename_unit

Parametrised N-wide register-rename stage placed between decode and dispatch. It maps architectural sources and destinations to physical registers through a map table and a circular free list, and resolves intra-group dependencies combinationally. It recycles physical registers returned by commit and supports multiple branch checkpoints with single-cycle restore. It supersedes the fixed 2-wide renamer and adds x0 handling, commit-side freeing, occupancy-based stalling and checkpoint management.

## Interface
- Width, 2: instructions renamed per group (lanes).
- NumArch, 32: architectural registers; AW = $clog2(NumArch).
- NumPhys, 64: physical registers; PW = $clog2(NumPhys); free-list depth FL = NumPhys-NumArch.
- NumCkpt, 4: checkpoint slots; CW = $clog2(NumCkpt).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- in_valid_i / in_ready_o  in/out  1  decode group handshake.
- in_rs1_i, in_rs2_i, in_rd_i  in  Width*AW  architectural indices, lane k at [k*AW +: AW].
- in_rd_we_i  in  Width  lane writes rd.
- in_save_i  in  1  take a checkpoint after this group.
- out_valid_o / out_ready_i  out/in  1  dispatch handshake.
- out_rs1_o, out_rs2_o, out_rd_o, out_old_rd_o  out  Width*PW  renamed fields.
- out_ckpt_id_o  out  CW  slot allocated for the group, valid only when the group had in_save_i set.
- commit_valid_i  in  Width  lanes returning a register.
- commit_old_rd_i  in  Width*PW  physical registers to free.
- restore_i  in  1  mispredict; restore_id_i  in  CW.
- ckpt_free_i  in  NumCkpt  one-hot-or-zero mask releasing slots.

## Operation
- FSM: StInit, then StRun.
  - Reset enters StInit: the map table is set to identity (arch i maps to phys i), checkpoints are marked free, and the pointers are cleared.
  - StInit writes phys NumArch+c into free-list entry c, one per cycle, for c = 0..FL-1. It moves to StRun after FL cycles. in_ready_o is 0 throughout StInit.
- Free list: a circular buffer with head and tail pointers, each log2(FL)+1 bits including a wrap bit. count = tail - head.
- Allocation: for lanes with in_rd_we_i=1 and rd!=0, taken in ascending lane order, the free-list entries are head, head+1, and so on. head advances by the number of such lanes.
- x0 handling:
  - rs==0 maps to phys 0.
  - A lane with rd==0 or in_rd_we_i=0 allocates nothing, and out_rd_o = out_old_rd_o = 0 for that lane.
- Intra-group bypass: for lane j, the rs1, rs2 and old_rd lookups take the rd allocated by the highest lane k<j with a matching, valid rd. Otherwise they read the map table.
- Map table update on accept: each rd gets its new physical register. When several lanes share an rd, the highest lane wins.
- Commit: each valid lane writes commit_old_rd_i at tail in lane order, and tail advances by popcount(commit_valid_i). Commit is never backpressured; FL bounds occupancy.
- Checkpoint save: on accept with in_save_i=1, the lowest free slot stores the post-group map table and post-group head. The slot is marked busy and its id is registered into out_ckpt_id_o.
- Restore:
  - Map table is loaded from slot restore_id_i and head from the saved head; tail is kept.
  - The slot is freed. out_valid_o is cleared and no group is accepted in that cycle.
  - Restore has priority over accept and over ckpt_free_i for the same slot.
- ckpt_free_i: marks the listed slots free on the next edge.

## Timing
- Accept: in_valid_i && in_ready_o.
- in_ready_o = StRun && !restore_i && (!out_valid_o || out_ready_i) && count >= popcount(allocating lanes) && (!in_save_i || a free slot exists).
- Latency is one cycle: a group accepted at edge n is on the outputs after edge n; the output register holds the fields.
- Outputs hold stable while out_valid_o && !out_ready_i.
- Map table, free-list and checkpoint effects of an accept are visible to the group accepted on the next cycle (back-to-back RAW).
- Commit and allocation in the same cycle: count changes by the net amount. Entries freed in cycle n become allocatable from cycle n+1.
- Reset values:
  - out_valid_o=0, in_ready_o=0, all out fields 0.
  - head=tail=0 during init; count=FL at StRun entry.
- Reset mid-operation returns to StInit and fully reinitialises state.
- A restore during StInit is ignored.

## Test plan
- Reset with Width=2, NumPhys=64: in_ready_o stays 0 for 32 cycles. The first group, rd=5 and rd=6, gets out_rd 32 and 33 with old_rd 5 and 6.
- Group lane0 "rd=3", lane1 "rs1=3, rs2=3, rd=3": lane1 rs1 = rs2 = lane0's new phys, old_rd = lane0's new phys, and the map table holds lane1's phys for 3.
- Drain the free list to 1 entry, then present 2 allocating lanes: in_ready_o=0. Then commit 1 register: the group is accepted on the following cycle.
- Save at group A (phys 32..33 allocated), rename 3 more groups, then restore_i with the id returned for A: the next group allocates phys 34, and its sources map as they did right after A.
- Fill all 4 checkpoint slots, then present in_save_i=1: stalled until ckpt_free_i=4'b0010, after which slot 1 is allocated.
- rd=0 with rs1=0: out_rd=0, out_rs1=0, head unchanged. Apply out_ready_i=0 for 3 cycles: outputs stay stable.
